axi_lite_reg_responder: RTL and testbench
=========================================

// Module: axi_lite_reg_responder
// PURPOSE
//  AXI4-Lite slave (responder) holding a 4-word register bank, driven by the processor-side AXI master in design_1.
//  Exports registers 0-2 as control outputs to fabric logic and returns a live fabric status word at register 3.
//  Runs on the 100 MHz system clock and is reset by the board reset.
// PARAMETERS
//  C_ADDR_WIDTH  4   byte-address width; word index is addr[3:2]
//  C_DATA_WIDTH  32  AXI data width; STRB width is C_DATA_WIDTH/8
//  C_RESET_VAL   0   reset value of control registers 0-2
// PORTS
//  clk_100MHz     in   1   system clock, rising edge
//  reset_rtl_0    in   1   asynchronous reset, active-high
//  s_awaddr       in   4   write address
//  s_awvalid      in   1   write address valid
//  s_awready      out  1   write address accepted
//  s_wdata        in   32  write data
//  s_wstrb        in   4   write byte strobes
//  s_wvalid       in   1   write data valid
//  s_wready       out  1   write data accepted
//  s_bresp        out  2   write response (00 OKAY, 10 SLVERR)
//  s_bvalid       out  1   write response valid
//  s_bready       in   1   master accepts write response
//  s_araddr       in   4   read address
//  s_arvalid      in   1   read address valid
//  s_arready      out  1   read address accepted
//  s_rdata        out  32  read data
//  s_rresp        out  2   read response (always 00)
//  s_rvalid       out  1   read data valid
//  s_rready       in   1   master accepts read data
//  ctrl0..ctrl2   out  32  registers 0-2 contents
//  status_in      in   32  fabric status, read as register 3
//  wr_pulse       out  3   one-cycle strobe per register 0-2 on a committed write
// BEHAVIOUR
//  Reset (async assert, sync release): all READY/VALID low, bresp/rresp 00, rdata 0, ctrl0..2 = C_RESET_VAL, wr_pulse 0.
//  Write FSM, states W_IDLE -> W_RESP:
//   - W_IDLE: when awvalid AND wvalid are both high, pulse awready and wready high for exactly that cycle.
//     Commit the write on the same edge and go to W_RESP. Either valid alone is not accepted and READY stays low.
//   - Commit: idx = awaddr[3:2]. For idx 0-2, byte n is updated only where wstrb[n]=1, and wr_pulse[idx]=1 for one cycle.
//     For idx 3 there is no update; bresp=10 SLVERR, otherwise 00.
//   - W_RESP: bvalid=1 on the cycle after the handshake and is held with bresp stable until bready; back to W_IDLE on the edge where bvalid&&bready.
//   - Earliest next aw/w accept is the cycle after the B handshake. awready/wready are never high in W_RESP.
//  Read FSM, states R_IDLE -> R_DATA:
//   - R_IDLE: arvalid -> arready pulses high 1 cycle; rdata is captured on that edge (idx 3 samples status_in then); go to R_DATA.
//   - R_DATA: rvalid=1 next cycle; rdata and rresp are held stable until rready; back to R_IDLE on the rvalid&&rready edge.
//  Read and write FSMs are independent. A simultaneous read and write to the same register returns the PRE-write value.
//  Address bits [1:0] are ignored (unaligned accesses map to the containing word).
//  wstrb=0000 is a legal write: OKAY response, no data change, wr_pulse still fires.
//  Reset asserted mid-transaction: pending B/R responses are dropped and the FSMs return to IDLE; the master must re-issue.
// TESTING
//  1 Reset release -> all READY/VALID 0, ctrl0..2 = 0, read of reg0 returns 0x00000000 OKAY.
//  2 Write 0xDEADBEEF to 0x4 (wstrb F), bready held 1 -> aw/wready pulse 1 cycle, bvalid next cycle, bresp 00;
//    ctrl1 = 0xDEADBEEF; wr_pulse = 3'b010 for one cycle.
//  3 Write 0x11223344 to 0x4 with wstrb 0101 -> ctrl1 = 0xDE22BE44.
//  4 awvalid high 5 cycles before wvalid -> no ready until wvalid rises; then a single accept.
//    Hold bready low 4 cycles -> bvalid stays 1 with bresp stable, no new accept.
//  5 status_in = 0xA5A5_0001, read 0xC with rready low 3 cycles -> rvalid held, rdata = 0xA5A50001.
//    Write to 0xC -> bresp 10, ctrl regs unchanged.
//  6 Assert reset_rtl_0 while bvalid=1 -> bvalid drops asynchronously, ctrl0..2 = 0.
//    After release a new write completes normally.

Source files
------------

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite responder with a 4-word register bank.
// Words 0-2 are byte-writable control registers exported to fabric logic.
// Word 3 is a read-only view of the live fabric status input; writes to it get SLVERR.
// The read and write channels run as independent two-state FSMs.

// One byte-strobed control register.
module axi_lite_ctrl_reg #(
    parameter int                  DW        = 32,
    parameter logic [DW-1:0]       RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [DW-1:0]          wdata,
    input  logic [DW/8-1:0]        wstrb,
    output logic [DW-1:0]          q
);
    // Only the strobed bytes change on a committed write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

module axi_lite_reg_responder #(
    parameter int                        C_ADDR_WIDTH = 4,
    parameter int                        C_DATA_WIDTH = 32,
    parameter logic [C_DATA_WIDTH-1:0]   C_RESET_VAL  = '0
) (
    input  logic                         clk_100MHz,
    input  logic                         reset_rtl_0,
    input  logic [C_ADDR_WIDTH-1:0]      s_awaddr,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [C_DATA_WIDTH-1:0]      s_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]    s_wstrb,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    output logic [1:0]                   s_bresp,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    input  logic [C_ADDR_WIDTH-1:0]      s_araddr,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [C_DATA_WIDTH-1:0]      s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rvalid,
    input  logic                         s_rready,
    output logic [C_DATA_WIDTH-1:0]      ctrl0,
    output logic [C_DATA_WIDTH-1:0]      ctrl1,
    output logic [C_DATA_WIDTH-1:0]      ctrl2,
    input  logic [C_DATA_WIDTH-1:0]      status_in,
    output logic [2:0]                   wr_pulse
);
    localparam int NUM_CTRL = 3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                                 aw_hs;
    logic                                 ar_hs;
    logic [1:0]                           w_idx;
    logic [1:0]                           r_idx;
    logic [NUM_CTRL-1:0]                  wr_sel;
    logic [NUM_CTRL-1:0][C_DATA_WIDTH-1:0] ctrl_q;
    logic [C_DATA_WIDTH-1:0]              rd_mux;

    // Byte-lane address bits carry no information for word-wide registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign w_idx = s_awaddr[3:2];
    assign r_idx = s_araddr[3:2];

    // Control register bank; each word commits only on its own address decode.
    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
        assign wr_sel[g] = aw_hs && (w_idx == 2'(g));
        axi_lite_ctrl_reg #(
            .DW        (C_DATA_WIDTH),
            .RESET_VAL (C_RESET_VAL)
        ) u_reg (
            .clk   (clk_100MHz),
            .rst   (reset_rtl_0),
            .we    (wr_sel[g]),
            .wdata (s_wdata),
            .wstrb (s_wstrb),
            .q     (ctrl_q[g])
        );
    end

    assign ctrl0 = ctrl_q[0];
    assign ctrl1 = ctrl_q[1];
    assign ctrl2 = ctrl_q[2];

    // Write FSM state register.
    always_ff @(posedge clk_100MHz or posedge reset_rtl_0) begin
        if (reset_rtl_0) w_state <= W_IDLE;
        else             w_state <= w_next;
    end

    // Write FSM: accept AW and W together in one cycle, then hold B until taken.
    always_comb begin
        w_next = w_state;
        aw_hs  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (s_awvalid && s_wvalid && !reset_rtl_0) begin
                    aw_hs  = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign s_awready = aw_hs;
    assign s_wready  = aw_hs;
    assign s_bvalid  = (w_state == W_RESP);

    // Response code and per-register strobe, both latched on the accept edge.
    always_ff @(posedge clk_100MHz or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            s_bresp  <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= wr_sel;
            if (aw_hs) s_bresp <= (w_idx == 2'd3) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk_100MHz or posedge reset_rtl_0) begin
        if (reset_rtl_0) r_state <= R_IDLE;
        else             r_state <= r_next;
    end

    // Read FSM: one-cycle AR accept, then hold R until taken.
    always_comb begin
        r_next = r_state;
        ar_hs  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (s_arvalid && !reset_rtl_0) begin
                    ar_hs  = 1'b1;
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign s_arready = ar_hs;
    assign s_rvalid  = (r_state == R_DATA);
    assign s_rresp   = RESP_OKAY;

    // Read mux sees register contents before any same-edge write lands.
    always_comb begin
        rd_mux = status_in;
        case (r_idx)
            2'd0:    rd_mux = ctrl_q[0];
            2'd1:    rd_mux = ctrl_q[1];
            2'd2:    rd_mux = ctrl_q[2];
            default: rd_mux = status_in;
        endcase
    end

    // Capture read data on the AR accept edge and hold it through R_DATA.
    always_ff @(posedge clk_100MHz or posedge reset_rtl_0) begin
        if (reset_rtl_0)  s_rdata <= '0;
        else if (ar_hs)   s_rdata <= rd_mux;
    end
endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Bench for axi_lite_reg_responder: vector table of single accesses plus
// hand-written handshake, concurrency and reset corner cases. B and R
// responses are checked against a scoreboard queue as the DUT hands them over.
module tb_axi_lite_reg_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [3:0]  s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] ctrl0, ctrl1, ctrl2;
    logic [31:0] status_in = '0;
    logic [2:0]  wr_pulse;

    axi_lite_reg_responder dut (
        .clk_100MHz (clk),       .reset_rtl_0 (rst),
        .s_awaddr   (s_awaddr),  .s_awvalid   (s_awvalid), .s_awready (s_awready),
        .s_wdata    (s_wdata),   .s_wstrb     (s_wstrb),   .s_wvalid  (s_wvalid),
        .s_wready   (s_wready),  .s_bresp     (s_bresp),   .s_bvalid  (s_bvalid),
        .s_bready   (s_bready),  .s_araddr    (s_araddr),  .s_arvalid (s_arvalid),
        .s_arready  (s_arready), .s_rdata     (s_rdata),   .s_rresp   (s_rresp),
        .s_rvalid   (s_rvalid),  .s_rready    (s_rready),
        .ctrl0 (ctrl0), .ctrl1 (ctrl1), .ctrl2 (ctrl2),
        .status_in  (status_in), .wr_pulse    (wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] status;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
        logic [31:0] exp_c0;
        logic [31:0] exp_c1;
        logic [31:0] exp_c2;
    } vec_t;

    vec_t        vecs[11];
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: compares each handed-over B/R beat with the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_bvalid && s_bready) begin
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", s_bresp, bq.pop_front());
            end
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else check("rdata_rresp", {s_rdata, s_rresp}, rq.pop_front());
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] eresp, input int aw_lead, input int b_hold);
        logic [2:0] epulse;
        int n;
        epulse = (addr[3:2] == 2'd3) ? 3'b000 : (3'b001 << addr[3:2]);
        bq.push_back(eresp);
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_bready = (b_hold == 0);
        for (int i = 0; i < aw_lead; i++) begin
            @(negedge clk);
            check("aw_alone_no_ready", {s_awready, s_wready}, 0);
            tick();
        end
        s_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(s_awready && s_wready) && n < 20) begin tick(); @(negedge clk); n++; end
        check("aw_w_accept", s_awready && s_wready, 1);
        tick();
        s_awvalid = (b_hold > 0); s_wvalid = (b_hold > 0);
        @(negedge clk);
        check("bvalid_after_hs", s_bvalid, 1);
        check("no_accept_in_resp", {s_awready, s_wready}, 0);
        check("wr_pulse", wr_pulse, epulse);
        for (int i = 0; i < b_hold; i++) begin
            tick(); @(negedge clk);
            check("bvalid_held", s_bvalid, 1);
            check("bresp_stable", s_bresp, eresp);
            check("no_accept_in_hold", {s_awready, s_wready}, 0);
        end
        if (b_hold > 0) begin
            tick();
            s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        end
        tick();
        n = 0;
        while (s_bvalid && n < 20) begin tick(); n++; end
        check("bvalid_drop", s_bvalid, 0);
        check("wr_pulse_one_cycle", wr_pulse, 0);
    endtask

    // Called and returns at posedge+1; status_in is scrambled after capture when holding.
    task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input int r_hold);
        int n;
        rq.push_back({exp, 2'b00});
        s_araddr = addr; s_arvalid = 1'b1; s_rready = (r_hold == 0);
        n = 0;
        @(negedge clk);
        while (!s_arready && n < 20) begin tick(); @(negedge clk); n++; end
        check("ar_accept", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
        if (r_hold > 0) status_in = ~status_in;
        @(negedge clk);
        check("rvalid_after_hs", s_rvalid, 1);
        for (int i = 0; i < r_hold; i++) begin
            if (i > 0) begin tick(); @(negedge clk); end
            check("rvalid_held", s_rvalid, 1);
            check("rdata_stable", s_rdata, exp);
        end
        if (r_hold > 0) begin tick(); s_rready = 1'b1; end
        tick();
        n = 0;
        while (s_rvalid && n < 20) begin tick(); n++; end
        check("rvalid_drop", s_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            wr addr  data          strb  status        exp_rd        resp   c0            c1            c2
        vecs[0]  = '{0, 4'h0, 32'h0,        4'h0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1, 4'h4, 32'hDEADBEEF, 4'hF, 32'h0,        32'h0,        2'b00, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1, 4'h4, 32'h11223344, 4'h5, 32'h0,        32'h0,        2'b00, 32'h0,        32'hDE22BE44, 32'h0};
        vecs[3]  = '{0, 4'h4, 32'h0,        4'h0, 32'h0,        32'hDE22BE44, 2'b00, 32'h0,        32'hDE22BE44, 32'h0};
        vecs[4]  = '{1, 4'h0, 32'hCAFEF00D, 4'h8, 32'h0,        32'h0,        2'b00, 32'hCA000000, 32'hDE22BE44, 32'h0};
        vecs[5]  = '{1, 4'hB, 32'h12345678, 4'hF, 32'h0,        32'h0,        2'b00, 32'hCA000000, 32'hDE22BE44, 32'h12345678};
        vecs[6]  = '{1, 4'h8, 32'hFFFFFFFF, 4'h0, 32'h0,        32'h0,        2'b00, 32'hCA000000, 32'hDE22BE44, 32'h12345678};
        vecs[7]  = '{0, 4'h9, 32'h0,        4'h0, 32'h0,        32'h12345678, 2'b00, 32'hCA000000, 32'hDE22BE44, 32'h12345678};
        vecs[8]  = '{0, 4'h2, 32'h0,        4'h0, 32'h0,        32'hCA000000, 2'b00, 32'hCA000000, 32'hDE22BE44, 32'h12345678};
        vecs[9]  = '{1, 4'hC, 32'h0BADF00D, 4'hF, 32'h0,        32'h0,        2'b10, 32'hCA000000, 32'hDE22BE44, 32'h12345678};
        vecs[10] = '{0, 4'hD, 32'h0,        4'h0, 32'h13579BDF, 32'h13579BDF, 2'b00, 32'hCA000000, 32'hDE22BE44, 32'h12345678};

        // Reset state, during and after reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {s_awready, s_wready, s_arready}, 0);
        check("rst_valid", {s_bvalid, s_rvalid}, 0);
        check("rst_ctrl", {ctrl0, ctrl1}, 0);
        check("rst_ctrl2_pulse", {ctrl2, wr_pulse}, 0);
        check("rst_resp_rdata", {s_bresp, s_rresp, s_rdata}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("post_rst_valid", {s_bvalid, s_rvalid, s_awready, s_arready}, 0);

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            status_in = vecs[i].status;
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, 0, 0);
            else
                do_read(vecs[i].addr, vecs[i].exp_rd, 0);
            check($sformatf("vec%0d_ctrl0", i), ctrl0, vecs[i].exp_c0);
            check($sformatf("vec%0d_ctrl1", i), ctrl1, vecs[i].exp_c1);
            check($sformatf("vec%0d_ctrl2", i), ctrl2, vecs[i].exp_c2);
        end

        // AW leads W by 5 cycles, then B held off for 4 cycles.
        do_write(4'h0, 32'h000000AA, 4'h1, 2'b00, 5, 4);
        check("lead_ctrl0", ctrl0, 32'hCA0000AA);

        // Status read with R held off; the captured word must survive status_in changing.
        status_in = 32'hA5A50001;
        do_read(4'hC, 32'hA5A50001, 3);
        do_write(4'hC, 32'hFFFFFFFF, 4'hF, 2'b10, 0, 0);
        check("slverr_ctrl", {ctrl0, ctrl1}, {32'hCA0000AA, 32'hDE22BE44});
        check("slverr_ctrl2", ctrl2, 32'h12345678);

        // Simultaneous read and write to the same word returns the old value.
        bq.push_back(2'b00);
        rq.push_back({32'hDE22BE44, 2'b00});
        s_awaddr = 4'h4; s_wdata = 32'h55555555; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = 4'h4; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clk);
        check("simul_accept", {s_awready, s_wready, s_arready}, 3'b111);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        @(negedge clk);
        check("simul_valids", {s_bvalid, s_rvalid}, 2'b11);
        tick();
        check("simul_ctrl1", ctrl1, 32'h55555555);
        check("simul_done", {s_bvalid, s_rvalid}, 0);

        // Reset while a B response is pending: it is dropped, not delivered.
        s_awaddr = 4'h8; s_wdata = 32'h1; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(negedge clk);
        check("mid_accept", s_awready, 1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        check("mid_bvalid", s_bvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_bvalid_drop", s_bvalid, 0);
        check("async_ctrl", {ctrl0, ctrl1}, 0);
        check("async_ctrl2_pulse", {ctrl2, wr_pulse}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        s_bready = 1'b1;
        tick();
        check("post_mid_rst_bvalid", s_bvalid, 0);
        do_write(4'h4, 32'h00000077, 4'hF, 2'b00, 0, 0);
        check("recover_ctrl1", ctrl1, 32'h00000077);
        do_read(4'h4, 32'h00000077, 0);

        tick();
        check("sb_drain", bq.size() + rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
